pe_ctrl_responder: RTL

- Clocked PE-side endpoint of the control-center start/done token protocol.
- Flow:
  - Accepts one start token.
  - Sequences a fixed number of compute operations on the local PE datapath via a go/done pulse pair.
  - Returns a single done token to the control center.
- One instance sits beside each PE, the adder and the memory wrapper, so the control center's broadcast/collect fork sees a well-behaved responder on every channel.

---
 rtl/pe_ctrl_pkg.sv | 14 +
 rtl/pe_ctrl_watchdog.sv | 26 ++
 rtl/pe_ctrl_responder.sv | 107 ++++++++++
 3 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the PE-side start/done token responder.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

    localparam int NUM_OPS_DEF     = 25;
    localparam int TIMEOUT_CYC_DEF = 1024;

    // Index width with a floor of one bit so NUM_OPS=1 still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_ctrl_watchdog.sv
// WAIT-cycle watchdog: cleared per operation, counts while enabled,
// flags the LIMIT-th enabled cycle. Only built with PE_CTRL_TIMEOUT_EN.
module pe_ctrl_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable && cnt != CW'(LIMIT))
            cnt <= cnt + CW'(1);
    end

    // cnt holds the number of enabled cycles already elapsed
    assign expire = enable && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/pe_ctrl_responder.sv
// PE-side endpoint of the start/done token protocol: one start token runs
// NUM_OPS go/done operations, then returns one done token. Optional
// watchdog under the PE_CTRL_TIMEOUT_EN macro.
module pe_ctrl_responder
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_OPS     = NUM_OPS_DEF,
    parameter int OP_W        = idx_w(NUM_OPS),
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic            start_flag,
    output logic            op_go,
    output logic [OP_W-1:0] op_idx,
    input  logic            op_done,
    output logic            done_valid,
    input  logic            done_ready,
    output logic            done_flag,
    output logic            done_err,
    output logic            busy
);
    state_t state;
    logic   flag;
    logic   wd_expire;
    logic   last_op;

    assign last_op = (op_idx == OP_W'(NUM_OPS - 1));

`ifdef PE_CTRL_TIMEOUT_EN
    pe_ctrl_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ISSUE),
        .enable (state == WAIT),
        .expire (wd_expire)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYC > 0);
    assign wd_expire      = 1'b0;
`endif

    // Every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_idx      <= '0;
            flag        <= 1'b0;
            start_ready <= 1'b1;
            op_go       <= 1'b0;
            done_valid  <= 1'b0;
            done_flag   <= 1'b0;
            done_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            op_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        flag        <= start_flag;
                        op_idx      <= '0;
                        state       <= ISSUE;
                        op_go       <= 1'b1;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // a completion in the expiry cycle takes priority
                    if (op_done) begin
                        if (last_op) begin
                            state      <= REPORT;
                            done_valid <= 1'b1;
                            done_flag  <= flag;
                            done_err   <= 1'b0;
                        end else begin
                            op_idx <= op_idx + OP_W'(1);
                            state  <= ISSUE;
                            op_go  <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        state      <= REPORT;
                        done_valid <= 1'b1;
                        done_flag  <= flag;
                        done_err   <= 1'b1;
                    end
                end
                REPORT: begin
                    if (done_ready) begin
                        state       <= IDLE;
                        done_valid  <= 1'b0;
                        done_flag   <= 1'b0;
                        done_err    <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
